// File: rtl/foodfight_pkg.sv
// Shared constants and state encoding for the program-ROM port arbiter.
package foodfight_pkg;

    localparam int unsigned ROM_AW = 13;
    localparam int unsigned ROM_DW = 8;
    localparam int unsigned CNT_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rom_port_arbiter_if.sv
// Requester/ROM signal bundle for the program-ROM port arbiter.
interface rom_port_arbiter_if #(
    parameter int unsigned AW = foodfight_pkg::ROM_AW,
    parameter int unsigned DW = foodfight_pkg::ROM_DW
);

    logic          req0;
    logic [AW-1:0] addr0;
    logic          ack0;
    logic [DW-1:0] data0;
    logic          req1;
    logic [AW-1:0] addr1;
    logic          ack1;
    logic [DW-1:0] data1;
    logic [AW-1:0] rom_a;
    logic [DW-1:0] rom_d;
    logic          busy;
    logic          gnt;

    // Arbiter side.
    modport slave (
        input  req0, addr0, req1, addr1, rom_d,
        output ack0, data0, ack1, data1, rom_a, busy, gnt
    );

    // Requesters plus ROM side.
    modport master (
        output req0, addr0, req1, addr1, rom_d,
        input  ack0, data0, ack1, data1, rom_a, busy, gnt
    );

endinterface

// File: rtl/rom_arb_pick.sv
// Fixed-priority pick with starvation override: port 0 wins unless port 1 has waited out the streak.
module rom_arb_pick (
    input  logic req0,
    input  logic req1,
    input  logic streak_full,
    output logic grant_valid,
    output logic grant_port
);

    always_comb begin
        grant_valid = req0 | req1;
        grant_port  = req1 & (~req0 | streak_full);
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Two-port arbiter for one synchronous program ROM: CPU fetch has priority,
// diagnostic reader is guaranteed a slot after STARVE_MAX back-to-back CPU grants.
module rom_port_arbiter
    import foodfight_pkg::*;
#(
    parameter int unsigned AW         = ROM_AW,
    parameter int unsigned DW         = ROM_DW,
    parameter int unsigned ROM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic               clk,
    input logic               reset_n,
    rom_port_arbiter_if.slave bus
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    streak_q, streak_d;
    logic [AW-1:0]    rom_a_q, rom_a_d;
    logic             gnt_q, gnt_d;
    logic [DW-1:0]    data0_q, data0_d;
    logic [DW-1:0]    data1_q, data1_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             busy_q, busy_d;

    logic streak_full;
    logic grant_valid;
    logic grant_port;

    assign streak_full = (streak_q == SW'(STARVE_MAX));

    rom_arb_pick u_pick (
        .req0        (bus.req0),
        .req1        (bus.req1),
        .streak_full (streak_full),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            streak_q <= '0;
            rom_a_q  <= '0;
            gnt_q    <= 1'b0;
            data0_q  <= '0;
            data1_q  <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            streak_q <= streak_d;
            rom_a_q  <= rom_a_d;
            gnt_q    <= gnt_d;
            data0_q  <= data0_d;
            data1_q  <= data1_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state logic. The edge that ends the ACK cycle arbitrates exactly like
    // IDLE, so a requester holding req sustains one access every ROM_LAT+2 clocks.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        streak_d = streak_q;
        rom_a_d  = rom_a_q;
        gnt_d    = gnt_q;
        data0_d  = data0_q;
        data1_d  = data1_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_ACK: begin
                if (grant_valid) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(ROM_LAT);
                    gnt_d   = grant_port;
                    rom_a_d = grant_port ? bus.addr1 : bus.addr0;
                    if (grant_port || !bus.req1) begin
                        streak_d = '0;
                    end else if (!streak_full) begin
                        streak_d = streak_q + SW'(1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Counter hits zero on the edge where ROM output is valid.
                if (cnt_q == '0) begin
                    state_d = ST_ACK;
                    if (gnt_q) begin
                        data1_d = bus.rom_d;
                        ack1_d  = 1'b1;
                    end else begin
                        data0_d = bus.rom_d;
                        ack0_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign bus.rom_a = rom_a_q;
    assign bus.gnt   = gnt_q;
    assign bus.data0 = data0_q;
    assign bus.data1 = data1_q;
    assign bus.ack0  = ack0_q;
    assign bus.ack1  = ack1_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter: one-clock-latency and three-clock-latency instances.
module tb_rom_port_arbiter;

    logic clk;
    logic reset_n;

    int n_checks;
    int n_fail;
    int ack0_cnt;
    int ack1_cnt;
    int ack_both;

    rom_port_arbiter_if bus1 ();
    rom_port_arbiter_if bus3 ();

    rom_port_arbiter #(.ROM_LAT(1), .STARVE_MAX(4)) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    rom_port_arbiter #(.ROM_LAT(3), .STARVE_MAX(4)) u_dut3 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus3)
    );

    // ROM image: ROM[0]=0x4E, ROM[0x1FFF]=0x4B, ROM[0x100..0x102]=0x46,0x45,0x40.
    function automatic logic [7:0] rom_word(input logic [12:0] a);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = a[7:0];
        hi = {3'b000, a[12:8]};
        return 8'(lo * 8'd3) ^ 8'(hi << 3) ^ 8'h4E;
    endfunction

    logic [7:0] rom3_p1;
    logic [7:0] rom3_p2;

    always @(posedge clk) begin
        bus1.rom_d <= rom_word(bus1.rom_a);
        rom3_p1    <= rom_word(bus3.rom_a);
        rom3_p2    <= rom3_p1;
        bus3.rom_d <= rom3_p2;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus1.ack0 && bus1.ack1) ack_both++;
        if (bus1.ack0) ack0_cnt++;
        if (bus1.ack1) ack1_cnt++;
    endtask

    task automatic wait_ack(input int max_cyc, output int ncyc, output logic hit);
        hit  = 1'b0;
        ncyc = 0;
        while (!hit && ncyc < max_cyc) begin
            tick();
            ncyc++;
            hit = bus1.ack0 | bus1.ack1;
        end
    endtask

    int         ncyc;
    logic       hit;
    int         c0;
    int         c1;
    int         clk_no;
    int         busy_wait;
    logic       exp_port;
    logic [7:0] exp_b2b [3];
    logic       exp_order [10];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ack0_cnt = 0;
        ack1_cnt = 0;
        ack_both = 0;
        exp_b2b  = '{8'h46, 8'h45, 8'h40};
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        reset_n    = 1'b0;
        bus1.req0  = 1'b0;
        bus1.req1  = 1'b0;
        bus1.addr0 = '0;
        bus1.addr1 = '0;
        bus3.req0  = 1'b0;
        bus3.req1  = 1'b0;
        bus3.addr0 = '0;
        bus3.addr1 = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", bus1.busy, 0);
        check_eq("rst_ack0", bus1.ack0, 0);
        check_eq("rst_ack1", bus1.ack1, 0);
        check_eq("rst_data0", bus1.data0, 0);
        check_eq("rst_data1", bus1.data1, 0);
        check_eq("rst_rom_a", bus1.rom_a, 0);
        check_eq("rst_gnt", bus1.gnt, 0);
        reset_n = 1'b1;
        tick();
        ack1_cnt = 0;

        // Single port-0 read of address 0
        bus1.addr0 = 13'h0000;
        bus1.req0  = 1'b1;
        tick();
        check_eq("single_busy_after_grant", bus1.busy, 1);
        check_eq("single_rom_a", bus1.rom_a, 13'h0000);
        check_eq("single_gnt", bus1.gnt, 0);
        check_eq("single_ack0_clk1", bus1.ack0, 0);
        tick();
        check_eq("single_ack0_clk2", bus1.ack0, 0);
        tick();
        check_eq("single_ack0_clk3", bus1.ack0, 1);
        check_eq("single_data0", bus1.data0, 8'h4E);
        bus1.req0 = 1'b0;
        tick();
        check_eq("single_ack0_clk4", bus1.ack0, 0);
        tick();
        check_eq("single_idle", bus1.busy, 0);
        check_eq("single_no_ack1", ack1_cnt, 0);

        // Contention: both held, streak limit gives port 1 every fifth slot
        bus1.addr0 = 13'h0010;
        bus1.addr1 = 13'h0A05;
        bus1.req0  = 1'b1;
        bus1.req1  = 1'b1;
        for (int t = 0; t < 10; t++) begin
            wait_ack(8, ncyc, hit);
            if (!hit) begin
                check_eq("cont_timeout", 0, 1);
                break;
            end
            exp_port = exp_order[t];
            if (t == 9) begin
                bus1.req0 = 1'b0;
                bus1.req1 = 1'b0;
            end
            check_eq($sformatf("cont%0d_port", t), bus1.ack1, exp_port);
            check_eq($sformatf("cont%0d_gnt", t), bus1.gnt, exp_port);
            check_eq($sformatf("cont%0d_period", t), ncyc, 3);
            if (exp_port) check_eq($sformatf("cont%0d_data1", t), bus1.data1, 8'h11);
            else          check_eq($sformatf("cont%0d_data0", t), bus1.data0, 8'h7E);
        end
        tick();
        tick();
        check_eq("cont_idle", bus1.busy, 0);

        // Back-to-back port-0 reads with advancing address
        c0 = ack0_cnt;
        bus1.addr0 = 13'h0100;
        bus1.req0  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_ack(8, ncyc, hit);
            if (!hit) begin
                check_eq("b2b_timeout", 0, 1);
                break;
            end
            check_eq($sformatf("b2b%0d_period", i), ncyc, 3);
            check_eq($sformatf("b2b%0d_data0", i), bus1.data0, exp_b2b[i]);
            if (i == 2) bus1.req0 = 1'b0;
            else        bus1.addr0 = bus1.addr0 + 13'd1;
        end
        repeat (4) tick();
        check_eq("b2b_ack_count", ack0_cnt - c0, 3);
        check_eq("b2b_idle", bus1.busy, 0);

        // Early release of port 1: transaction still completes once
        c1 = ack1_cnt;
        bus1.addr1 = 13'h0042;
        bus1.req1  = 1'b1;
        tick();
        bus1.req1 = 1'b0;
        repeat (6) tick();
        check_eq("early_ack1_count", ack1_cnt - c1, 1);
        check_eq("early_data1", bus1.data1, 8'h88);
        check_eq("early_idle", bus1.busy, 0);

        // Three-clock ROM latency, top address on port 1
        bus3.addr1 = 13'h1FFF;
        bus3.req1  = 1'b1;
        tick();
        bus3.req1 = 1'b0;
        check_eq("lat3_busy", bus3.busy, 1);
        check_eq("lat3_rom_a", bus3.rom_a, 13'h1FFF);
        check_eq("lat3_gnt", bus3.gnt, 1);
        clk_no    = 1;
        busy_wait = 1;
        while (!bus3.ack1 && clk_no < 12) begin
            tick();
            clk_no++;
            if (bus3.busy && !bus3.ack1) busy_wait++;
        end
        check_eq("lat3_ack_clock", clk_no, 5);
        check_eq("lat3_busy_wait", busy_wait, 4);
        check_eq("lat3_busy_in_ack", bus3.busy, 1);
        check_eq("lat3_data1", bus3.data1, 8'h4B);
        check_eq("lat3_ack0", bus3.ack0, 0);
        tick();
        check_eq("lat3_ack1_drop", bus3.ack1, 0);
        check_eq("lat3_idle", bus3.busy, 0);

        // Asynchronous reset while waiting on the ROM
        bus1.addr0 = 13'h0123;
        bus1.req0  = 1'b1;
        tick();
        bus1.req0 = 1'b0;
        check_eq("arst_busy_before", bus1.busy, 1);
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("arst_busy", bus1.busy, 0);
        check_eq("arst_ack0", bus1.ack0, 0);
        check_eq("arst_ack1", bus1.ack1, 0);
        check_eq("arst_data0", bus1.data0, 0);
        check_eq("arst_data1", bus1.data1, 0);
        check_eq("arst_rom_a", bus1.rom_a, 0);
        @(negedge clk);
        reset_n = 1'b1;
        c0 = ack0_cnt;
        repeat (5) tick();
        check_eq("arst_no_ack", ack0_cnt - c0, 0);
        bus1.req0 = 1'b1;
        wait_ack(8, ncyc, hit);
        bus1.req0 = 1'b0;
        check_eq("arst_retry_hit", hit, 1);
        check_eq("arst_retry_period", ncyc, 3);
        check_eq("arst_retry_port", bus1.ack0, 1);
        check_eq("arst_retry_data0", bus1.data0, 8'h2F);
        tick();
        tick();
        check_eq("arst_retry_idle", bus1.busy, 0);

        check_eq("acks_exclusive", ack_both, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
